// File: rtl/alarm_pkg.sv
// Shared types and 7-segment constants for the door alarm sequencer.
package alarm_pkg;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_A     = 8'h77;

  // Active-high {dp,g,f,e,d,c,b,a}; values outside 1..9 are blanked.
  function automatic logic [7:0] seg_digit(input logic [3:0] value);
    logic [7:0] pattern;
    pattern = SEG_BLANK;
    case (value)
      4'd1:    pattern = 8'h06;
      4'd2:    pattern = 8'h5B;
      4'd3:    pattern = 8'h4F;
      4'd4:    pattern = 8'h66;
      4'd5:    pattern = 8'h6D;
      4'd6:    pattern = 8'h7D;
      4'd7:    pattern = 8'h07;
      4'd8:    pattern = 8'h7F;
      4'd9:    pattern = 8'h6F;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational single-digit 7-segment encoder for the countdown display.
module seg7_digit
  import alarm_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg_digit(value_i);

endmodule

// File: rtl/alarm_sequencer.sv
// Door alarm back end: exit delay, entry delay and a latched blinking siren,
// with Moore-decoded LEDs, 7-seg countdown and a debug state code.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int EXIT_TICKS  = 5,
  parameter int ENTRY_TICKS = 3
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       arm,
  input  logic       door,
  input  logic       clear,
  output logic       led_armed,
  output logic       led_siren,
  output logic [7:0] seg,
  output logic [2:0] state_o
);

  localparam int CNT_W = $clog2(max_int(EXIT_TICKS, ENTRY_TICKS) + 1);
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_TICKS - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             siren_q, siren_d;
  logic [3:0]       digit_val;
  logic [7:0]       digit_seg;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_DISARMED;
      cnt_q   <= '0;
      siren_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      siren_q <= siren_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    siren_d = siren_q;
    if (clear) begin
      state_d = S_DISARMED;
      cnt_d   = '0;
      siren_d = 1'b0;
    end else begin
      case (state_q)
        S_DISARMED: begin
          if (arm) begin
            state_d = S_EXIT;
            cnt_d   = EXIT_LOAD;
          end
        end
        S_EXIT: begin
          if (!arm)              state_d = S_DISARMED;
          else if (cnt_q == '0)  state_d = S_ARMED;
          else                   cnt_d   = cnt_q - CNT_ONE;
        end
        S_ARMED: begin
          if (!arm) begin
            state_d = S_DISARMED;
          end else if (door) begin
            state_d = S_ENTRY;
            cnt_d   = ENTRY_LOAD;
          end
        end
        S_ENTRY: begin
          if (!arm) begin
            state_d = S_DISARMED;
          end else if (cnt_q == '0) begin
            state_d = S_ALARM;
            siren_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        // Latched: only clear (handled above) leaves ALARM.
        S_ALARM: siren_d = ~siren_q;
        default: begin
          state_d = S_DISARMED;
          cnt_d   = '0;
          siren_d = 1'b0;
        end
      endcase
    end
  end

  // The display shows cycles remaining, i.e. one more than the down-counter.
  assign digit_val = 4'(cnt_q) + 4'd1;

  seg7_digit u_digit (
    .value_i (digit_val),
    .seg_o   (digit_seg)
  );

  always_comb begin
    led_armed = 1'b0;
    led_siren = 1'b0;
    seg       = SEG_BLANK;
    state_o   = state_q;
    case (state_q)
      S_EXIT:  seg = digit_seg;
      S_ARMED: led_armed = 1'b1;
      S_ENTRY: begin
        led_armed = 1'b1;
        seg       = digit_seg;
      end
      S_ALARM: begin
        led_armed = 1'b1;
        led_siren = siren_q;
        seg       = SEG_A;
      end
      default: begin
        led_armed = 1'b0;
        seg       = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios plus random
// stimulus against a cycles-remaining reference model.
module tb_alarm_sequencer;

  localparam int EXIT_T  = 5;
  localparam int ENTRY_T = 3;
  localparam int M_DIS = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;

  logic       clk_2 = 1'b0;
  logic       reset_n, arm, door, clear;
  logic       led_armed, led_siren;
  logic [7:0] seg;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] digit_tab [0:9] = '{8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [7:0] exit_seq  [0:4] = '{8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};
  logic [7:0] entry_seq [0:2] = '{8'h4F, 8'h5B, 8'h06};

  // Reference model: phase, cycles remaining in a delay, cycles spent in alarm.
  int m_state, m_rem, m_age;

  alarm_sequencer #(.EXIT_TICKS(EXIT_T), .ENTRY_TICKS(ENTRY_T)) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .arm       (arm),
    .door      (door),
    .clear     (clear),
    .led_armed (led_armed),
    .led_siren (led_siren),
    .seg       (seg),
    .state_o   (state_o)
  );

  always #5 clk_2 = ~clk_2;

  task automatic model_reset();
    m_state = M_DIS;
    m_rem   = 0;
    m_age   = 0;
  endtask

  task automatic model_step(input logic a, input logic d, input logic c);
    if (c) begin
      model_reset();
    end else begin
      case (m_state)
        M_DIS:   if (a) begin m_state = M_EXIT; m_rem = EXIT_T; end
        M_EXIT:  if (!a) m_state = M_DIS;
                 else begin
                   m_rem--;
                   if (m_rem == 0) m_state = M_ARMED;
                 end
        M_ARMED: if (!a) m_state = M_DIS;
                 else if (d) begin m_state = M_ENTRY; m_rem = ENTRY_T; end
        M_ENTRY: if (!a) m_state = M_DIS;
                 else begin
                   m_rem--;
                   if (m_rem == 0) begin m_state = M_ALARM; m_age = 0; end
                 end
        default: m_age++;
      endcase
    end
  endtask

  function automatic logic [12:0] expected();
    logic       e_armed, e_siren;
    logic [7:0] e_seg;
    e_armed = (m_state == M_ARMED) || (m_state == M_ENTRY) || (m_state == M_ALARM);
    e_siren = (m_state == M_ALARM) && (m_age % 2 == 0);
    e_seg   = 8'h00;
    if (m_state == M_EXIT || m_state == M_ENTRY) e_seg = digit_tab[m_rem];
    else if (m_state == M_ALARM)                 e_seg = 8'h77;
    return {e_armed, e_siren, e_seg, 3'(m_state)};
  endfunction

  function automatic logic [12:0] observed();
    return {led_armed, led_siren, seg, state_o};
  endfunction

  // Drive after a falling edge, let the rising edge act, return on the next falling edge.
  task automatic cycle(input logic a, input logic d, input logic c);
    arm = a; door = d; clear = c;
    @(posedge clk_2);
    model_step(a, d, c);
    @(negedge clk_2);
  endtask

  task automatic goto_armed();
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < EXIT_T + 1; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic goto_alarm();
    goto_armed();
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < ENTRY_T; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; arm = 1'b0; door = 1'b0; clear = 1'b0;
    model_reset();
    #3;
    total++;
    if (observed() !== 13'h0) begin
      bad++;
      $display("FAIL reset_no_clock: got %h want %h", observed(), 13'h0);
    end
    arm = 1'b1;
    @(negedge clk_2);
    total++;
    if (observed() !== 13'h0) begin
      bad++;
      $display("FAIL reset_held: got %h want %h", observed(), 13'h0);
    end
    arm = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_exit_delay();
    for (int i = 0; i < EXIT_T; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      total++;
      if (seg !== exit_seq[i] || observed() !== expected()) begin
        bad++;
        $display("FAIL exit_seq[%0d]: got %h seg %h want %h seg %h",
                 i, observed(), seg, expected(), exit_seq[i]);
      end
    end
    cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (state_o !== 3'd2 || led_armed !== 1'b1 || seg !== 8'h00) begin
      bad++;
      $display("FAIL exit_to_armed: got state %0d armed %b seg %h want 2 1 00",
               state_o, led_armed, seg);
    end
  endtask

  task automatic test_entry_alarm();
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < ENTRY_T; i++) begin
      total++;
      if (seg !== entry_seq[i] || observed() !== expected()) begin
        bad++;
        $display("FAIL entry_seq[%0d]: got %h seg %h want %h seg %h",
                 i, observed(), seg, expected(), entry_seq[i]);
      end
      cycle(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (seg !== 8'h77 || led_siren !== logic'(i % 2 == 0) || observed() !== expected()) begin
        bad++;
        $display("FAIL alarm_blink[%0d]: got siren %b seg %h want siren %b seg 77",
                 i, led_siren, seg, logic'(i % 2 == 0));
      end
      cycle(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_disarm_in_entry();
    bit siren_seen = 1'b0;
    goto_armed();
    cycle(1'b1, 1'b1, 1'b0);
    siren_seen |= led_siren;
    cycle(1'b1, 1'b0, 1'b0);
    siren_seen |= led_siren;
    cycle(1'b0, 1'b0, 1'b0);
    siren_seen |= led_siren;
    total++;
    if (state_o !== 3'd0 || seg !== 8'h00 || siren_seen || observed() !== expected()) begin
      bad++;
      $display("FAIL disarm_in_entry: got state %0d seg %h siren_seen %b want 0 00 0",
               state_o, seg, siren_seen);
    end
  endtask

  task automatic test_alarm_latched();
    goto_alarm();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      total++;
      if (state_o !== 3'd4 || observed() !== expected()) begin
        bad++;
        $display("FAIL alarm_latched[%0d]: got %h want %h", i, observed(), expected());
      end
    end
    cycle(1'b0, 1'b0, 1'b1);
    total++;
    if (state_o !== 3'd0 || led_siren !== 1'b0 || observed() !== expected()) begin
      bad++;
      $display("FAIL alarm_clear: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_exit_door_toggle();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= EXIT_T; i++) begin
      cycle(1'b1, logic'(i % 2 == 1), 1'b0);
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL exit_door_toggle[%0d]: got %h want %h", i, observed(), expected());
      end
    end
    total++;
    if (state_o !== 3'd2) begin
      bad++;
      $display("FAIL exit_door_ignored: got state %0d want 2", state_o);
    end
  endtask

  task automatic test_async_reset();
    goto_alarm();
    cycle(1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (observed() !== 13'h0) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", observed(), 13'h0);
    end
    @(negedge clk_2);
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (observed() !== expected()) begin
      bad++;
      $display("FAIL after_reset: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_clear_priority();
    cycle(1'b1, 1'b0, 1'b1);
    total++;
    if (state_o !== 3'd0 || observed() !== expected()) begin
      bad++;
      $display("FAIL clear_with_arm: got state %0d want 0", state_o);
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    total++;
    if (state_o !== 3'd0 || observed() !== expected()) begin
      bad++;
      $display("FAIL clear_in_exit: got state %0d want 0", state_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(3, 0) != 0),
            logic'($urandom_range(3, 0) == 0),
            logic'($urandom_range(15, 0) == 0));
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_exit_delay();
    test_entry_alarm();
    test_disarm_in_entry();
    test_alarm_latched();
    test_exit_door_toggle();
    test_async_reset();
    test_clear_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
